jtag_dr_ir_regs: RTL and testbench

Instruction register and data-register bank for the JTAG TAP, sitting directly downstream of `tap_fsm`. It consumes the TAP's current state code and TDI, and it implements:

- an IR_WIDTH-bit instruction register;
- the BYPASS, IDCODE and USER data registers;
- the TDO mux.

It exposes a parallel capture/update port so the core can exchange a USER_WIDTH-bit word with the debugger.

---
 rtl/jtag_pkg.sv | 41 ++++
 rtl/jtag_shift_reg.sv | 45 ++++
 rtl/jtag_dr_ir_regs.sv | 145 ++++++++++++++
 tb/tb_jtag_dr_ir_regs.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// ============================================================================
// Module   : jtag_pkg
// Brief    : TAP state codes (shared with tap_fsm), opcodes and DR selection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_pkg;

  typedef enum logic [3:0] {
    TL_RESET   = 4'd0,
    RUN_IDLE   = 4'd1,
    SELECT_DR  = 4'd2,
    CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SELECT_IR  = 4'd9,
    CAPTURE_IR = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } tap_state_e;

  localparam logic [3:0] OP_IDCODE = 4'b0001;
  localparam logic [3:0] OP_USER   = 4'b1000;
  localparam logic [3:0] OP_BYPASS = 4'b1111;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage

`default_nettype wire

// File: rtl/jtag_shift_reg.sv
// ============================================================================
// Module   : jtag_shift_reg
// Brief    : Capture/shift register, LSB shifted out, serial input enters MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] capture_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shifted = sin;
    end else begin : g_wn
      assign w_shifted = {sin, r_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (capture) begin
      r_q <= capture_data;
    end else if (shift) begin
      r_q <= w_shifted;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/jtag_dr_ir_regs.sv
// ============================================================================
// Module   : jtag_dr_ir_regs
// Brief    : JTAG instruction register, BYPASS/IDCODE/USER data regs, TDO mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_dr_ir_regs
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          USER_WIDTH = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            tap_state,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [IR_WIDTH-1:0]   ir_out,
  input  logic [USER_WIDTH-1:0] user_capture_data,
  output logic [USER_WIDTH-1:0] user_update_data,
  output logic                  user_update
);

  localparam logic [IR_WIDTH-1:0] c_op_idcode  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] c_op_user    = IR_WIDTH'(OP_USER);
  localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(2'b01);

  logic w_tl_reset, w_capture_ir, w_shift_ir, w_update_ir;
  logic w_capture_dr, w_shift_dr, w_update_dr;

  assign w_tl_reset   = (tap_state == TL_RESET);
  assign w_capture_ir = (tap_state == CAPTURE_IR);
  assign w_shift_ir   = (tap_state == SHIFT_IR);
  assign w_update_ir  = (tap_state == UPDATE_IR);
  assign w_capture_dr = (tap_state == CAPTURE_DR);
  assign w_shift_dr   = (tap_state == SHIFT_DR);
  assign w_update_dr  = (tap_state == UPDATE_DR);

  logic [IR_WIDTH-1:0]   r_ir;
  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [31:0]           r_id_shift;
  logic [USER_WIDTH-1:0] r_user_shift;
  logic                  r_bypass;
  logic [USER_WIDTH-1:0] r_user_update_data;
  logic                  r_user_update;
  dr_sel_e               w_sel;

  // Unknown opcodes fall through to BYPASS.
  always_comb begin
    w_sel = DR_BYPASS;
    if (r_ir == c_op_idcode) begin
      w_sel = DR_IDCODE;
    end else if (r_ir == c_op_user) begin
      w_sel = DR_USER;
    end
  end

  jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_shift (
    .clk          (clk),
    .reset        (reset),
    .capture      (w_capture_ir),
    .shift        (w_shift_ir),
    .sin          (tdi),
    .capture_data (c_ir_capture),
    .q            (r_ir_shift)
  );

  jtag_shift_reg #(.WIDTH(32)) u_id_shift (
    .clk          (clk),
    .reset        (reset),
    .capture      (w_capture_dr && (w_sel == DR_IDCODE)),
    .shift        (w_shift_dr && (w_sel == DR_IDCODE)),
    .sin          (tdi),
    .capture_data (IDCODE_VAL),
    .q            (r_id_shift)
  );

  jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_user_shift (
    .clk          (clk),
    .reset        (reset),
    .capture      (w_capture_dr && (w_sel == DR_USER)),
    .shift        (w_shift_dr && (w_sel == DR_USER)),
    .sin          (tdi),
    .capture_data (user_capture_data),
    .q            (r_user_shift)
  );

  // Only the LSB of the ID register leaves the block; upper bits just shift.
  logic w_unused_id;
  assign w_unused_id = ^r_id_shift[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bypass <= 1'b0;
    end else if (w_capture_dr && (w_sel == DR_BYPASS)) begin
      r_bypass <= 1'b0;
    end else if (w_shift_dr && (w_sel == DR_BYPASS)) begin
      r_bypass <= tdi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_tl_reset) begin
      r_ir <= c_op_idcode;
    end else if (w_update_ir) begin
      r_ir <= r_ir_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_user_update_data <= '0;
      r_user_update      <= 1'b0;
    end else begin
      r_user_update <= w_update_dr && (w_sel == DR_USER);
      if (w_update_dr && (w_sel == DR_USER)) begin
        r_user_update_data <= r_user_shift;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (w_shift_ir) begin
      tdo = r_ir_shift[0];
    end else if (w_shift_dr) begin
      case (w_sel)
        DR_IDCODE: tdo = r_id_shift[0];
        DR_USER:   tdo = r_user_shift[0];
        default:   tdo = r_bypass;
      endcase
    end
  end

  assign tdo_en           = w_shift_ir || w_shift_dr;
  assign ir_out           = r_ir;
  assign user_update_data = r_user_update_data;
  assign user_update      = r_user_update;

endmodule

`default_nettype wire

// File: tb/tb_jtag_dr_ir_regs.sv
// ============================================================================
// Module   : tb_jtag_dr_ir_regs
// Brief    : Scoreboard bench driving TAP state codes into jtag_dr_ir_regs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_dr_ir_regs;
  import jtag_pkg::*;

  localparam int          IRW = 4;
  localparam int          UW  = 32;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     tap_state = TL_RESET;
  logic           tdi = 1'b0;
  logic           tdo;
  logic           tdo_en;
  logic [IRW-1:0] ir_out;
  logic [UW-1:0]  user_capture_data = '0;
  logic [UW-1:0]  user_update_data;
  logic           user_update;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic obs_q[$];

  jtag_dr_ir_regs #(
    .IR_WIDTH   (IRW),
    .USER_WIDTH (UW),
    .IDCODE_VAL (IDV)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tap_state         (tap_state),
    .tdi               (tdi),
    .tdo               (tdo),
    .tdo_en            (tdo_en),
    .ir_out            (ir_out),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update       (user_update)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Drive one TAP cycle; shift-state TDO is recorded before the shifting edge.
  task automatic step(input logic [3:0] st, input logic d);
    @(negedge clk);
    tap_state = st;
    tdi       = d;
    #1;
    if (st == SHIFT_DR || st == SHIFT_IR) obs_q.push_back(tdo);
  endtask

  task automatic ir_scan(input logic [IRW-1:0] op);
    step(SELECT_DR, 1'b0);
    step(SELECT_IR, 1'b0);
    step(CAPTURE_IR, 1'b0);
    for (int i = 0; i < IRW; i++) begin
      exp_q.push_back(i == 0);
      step(SHIFT_IR, op[i]);
    end
    step(EXIT1_IR, 1'b0);
    step(UPDATE_IR, 1'b0);
    step(RUN_IDLE, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] data);
    step(SELECT_DR, 1'b0);
    step(CAPTURE_DR, 1'b0);
    for (int i = 0; i < n; i++) step(SHIFT_DR, data[i]);
    step(EXIT1_DR, 1'b0);
    step(UPDATE_DR, 1'b0);
  endtask

  task automatic test_reset;
    step(TL_RESET, 1'b0);
    step(TL_RESET, 1'b0);
    checks++;
    if (ir_out !== 4'b0001) begin errors++; $display("FAIL reset_ir: got %b expected 0001", ir_out); end
    checks++;
    if ({tdo, tdo_en, user_update} !== 3'b000) begin
      errors++; $display("FAIL reset_outs: got tdo/en/upd %b expected 000", {tdo, tdo_en, user_update});
    end
    checks++;
    if (user_update_data !== '0) begin errors++; $display("FAIL reset_user_data: got %h expected 0", user_update_data); end
    reset = 1'b0;
    step(RUN_IDLE, 1'b0);
  endtask

  task automatic test_idcode;
    for (int i = 0; i < 32; i++) exp_q.push_back(IDV[i]);
    dr_scan(32, 64'd0);
    step(RUN_IDLE, 1'b0);
    checks++;
    if (ir_out !== 4'b0001) begin errors++; $display("FAIL idcode_ir: got %b expected 0001", ir_out); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL idcode_count: got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL idcode_tdo bit %0d: got %b expected %b", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_bypass;
    logic [2:0] pat;
    pat = 3'b101;
    ir_scan(4'b1111);
    checks++;
    if (ir_out !== 4'b1111) begin errors++; $display("FAIL bypass_ir: got %b expected 1111", ir_out); end
    for (int i = 0; i < 3; i++) exp_q.push_back((i == 0) ? 1'b0 : pat[i-1]);
    dr_scan(3, {61'd0, pat});
    step(RUN_IDLE, 1'b0);
    checks++;
    if ({tdo, tdo_en} !== 2'b00) begin errors++; $display("FAIL idle_tdo: got tdo/en %b expected 00", {tdo, tdo_en}); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bypass_count: got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL bypass_tdo bit %0d: got %b expected %b", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_user;
    logic [31:0] cap, din;
    cap = 32'hA5A5_0F0F;
    din = 32'h1234_5678;
    user_capture_data = cap;
    ir_scan(4'b1000);
    checks++;
    if (ir_out !== 4'b1000) begin errors++; $display("FAIL user_ir: got %b expected 1000", ir_out); end
    for (int i = 0; i < 32; i++) exp_q.push_back(cap[i]);
    dr_scan(32, {32'd0, din});
    checks++;
    if (user_update !== 1'b0) begin errors++; $display("FAIL user_early_pulse: got %b expected 0", user_update); end
    step(RUN_IDLE, 1'b0);
    checks++;
    if (user_update !== 1'b1) begin errors++; $display("FAIL user_pulse: got %b expected 1", user_update); end
    checks++;
    if (user_update_data !== din) begin errors++; $display("FAIL user_data: got %h expected %h", user_update_data, din); end
    step(RUN_IDLE, 1'b0);
    checks++;
    if (user_update !== 1'b0) begin errors++; $display("FAIL user_pulse_len: got %b expected 0", user_update); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL user_count: got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL user_tdo bit %0d: got %b expected %b", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_user_pause;
    logic [31:0] cap, din;
    cap = 32'h3C3C_C3C3;
    din = 32'hDEAD_BEEF;
    user_capture_data = cap;
    for (int i = 0; i < 32; i++) exp_q.push_back(cap[i]);
    step(SELECT_DR, 1'b0);
    step(CAPTURE_DR, 1'b0);
    for (int i = 0; i < 16; i++) step(SHIFT_DR, din[i]);
    checks++;
    if (tdo_en !== 1'b1) begin errors++; $display("FAIL shift_tdo_en: got %b expected 1", tdo_en); end
    step(EXIT1_DR, 1'b1);
    for (int i = 0; i < 5; i++) step(PAUSE_DR, 1'b1);
    checks++;
    if ({tdo, tdo_en} !== 2'b00) begin errors++; $display("FAIL pause_tdo: got tdo/en %b expected 00", {tdo, tdo_en}); end
    step(EXIT2_DR, 1'b1);
    for (int i = 16; i < 32; i++) step(SHIFT_DR, din[i]);
    step(EXIT1_DR, 1'b0);
    step(UPDATE_DR, 1'b0);
    step(RUN_IDLE, 1'b0);
    checks++;
    if (user_update !== 1'b1) begin errors++; $display("FAIL pause_pulse: got %b expected 1", user_update); end
    checks++;
    if (user_update_data !== din) begin errors++; $display("FAIL pause_data: got %h expected %h", user_update_data, din); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pause_count: got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL pause_tdo bit %0d: got %b expected %b", i, o, e); end
    end
    obs_q.delete();
    step(RUN_IDLE, 1'b0);
  endtask

  task automatic test_illegal;
    logic [7:0] pat;
    pat = 8'b1011_0010;
    ir_scan(4'b0110);
    checks++;
    if (ir_out !== 4'b0110) begin errors++; $display("FAIL illegal_ir: got %b expected 0110", ir_out); end
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 0) ? 1'b0 : pat[i-1]);
    dr_scan(8, {56'd0, pat});
    for (int k = 0; k < 3; k++) begin
      step(RUN_IDLE, 1'b0);
      checks++;
      if (user_update !== 1'b0) begin errors++; $display("FAIL illegal_pulse cyc %0d: got %b expected 0", k, user_update); end
    end
    checks++;
    if (user_update_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL illegal_data: got %h expected deadbeef", user_update_data);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL illegal_count: got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin errors++; $display("FAIL illegal_tdo bit %0d: got %b expected %b", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_scan;
    ir_scan(4'b1000);
    user_capture_data = 32'hFFFF_FFFF;
    step(SELECT_DR, 1'b0);
    step(CAPTURE_DR, 1'b0);
    for (int i = 0; i < 10; i++) step(SHIFT_DR, 1'b1);
    @(negedge clk);
    reset     = 1'b1;
    tap_state = SHIFT_DR;
    tdi       = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    tap_state = TL_RESET;
    tdi       = 1'b0;
    #1;
    checks++;
    if (ir_out !== 4'b0001) begin errors++; $display("FAIL midreset_ir: got %b expected 0001", ir_out); end
    checks++;
    if ({tdo, tdo_en, user_update} !== 3'b000) begin
      errors++; $display("FAIL midreset_outs: got tdo/en/upd %b expected 000", {tdo, tdo_en, user_update});
    end
    checks++;
    if (user_update_data !== '0) begin errors++; $display("FAIL midreset_data: got %h expected 0", user_update_data); end
    exp_q.delete();
    obs_q.delete();
    // After reset the IDCODE register must again be selected and captured.
    step(RUN_IDLE, 1'b0);
    step(SELECT_DR, 1'b0);
    step(CAPTURE_DR, 1'b0);
    step(SHIFT_DR, 1'b0);
    step(SHIFT_DR, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== IDV[0] || obs_q[1] !== IDV[1]) begin
      errors++; $display("FAIL midreset_idcode: got %0d bits first %b expected %b%b", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0] : 1'bx, IDV[1], IDV[0]);
    end
    obs_q.delete();
    step(EXIT1_DR, 1'b0);
    step(UPDATE_DR, 1'b0);
    step(RUN_IDLE, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_user_pause();
    test_illegal();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
